// File: rtl/aes_out_serializer_if.sv
// Bundle between AES_top, the block-to-word serializer and its narrow consumer.
// Carries word_parity only when AES_OUT_PARITY_EN is defined.
interface aes_out_serializer_if #(
  parameter int DEPTH = 2
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic          AES_data_out_valid;
  logic [127:0]  AES_data_out;
  logic          word_ready;
  logic          word_valid;
  logic [31:0]   word_data;
  logic          word_last;
  logic [LW-1:0] buf_level;
  logic          overflow;
`ifdef AES_OUT_PARITY_EN
  logic          word_parity;
`endif

  modport master (
    input  AES_data_out_valid,
    input  AES_data_out,
    input  word_ready,
    output word_valid,
    output word_data,
    output word_last,
    output buf_level,
    output overflow
`ifdef AES_OUT_PARITY_EN
    , output word_parity
`endif
  );

  modport slave (
    output AES_data_out_valid,
    output AES_data_out,
    output word_ready,
    input  word_valid,
    input  word_data,
    input  word_last,
    input  buf_level,
    input  overflow
`ifdef AES_OUT_PARITY_EN
    , input word_parity
`endif
  );
endinterface

// File: rtl/aes_out_serializer.sv
// Captures AES_top result blocks into a small FIFO and drains them as 32-bit words.
// Optional macro AES_OUT_PARITY_EN adds an even-parity bit per emitted word.
module aes_out_serializer #(
  parameter int DEPTH     = 2,
  parameter bit MSW_FIRST = 1'b1
) (
  input  logic                 AES_clk,
  input  logic                 AES_rst_n,
  aes_out_serializer_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [127:0]  mem_q [DEPTH];
  logic          prev_v_q, prev_v_d;
  logic [1:0]    idx_q, idx_d;
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [LW-1:0] level_q, level_d;
  logic          ovf_q, ovf_d;

  logic          wvalid_s, xfer_s, pop_s, cap_s, full_s, accept_s, drop_s;
  logic [1:0]    sel_s;
  logic [127:0]  head_blk_s;
  logic [31:0]   word_s;

`ifdef AES_OUT_PARITY_EN
  function automatic logic even_parity(input logic [31:0] w);
    return ^w;
  endfunction
`endif

  // Handshake and FIFO event decode.
  always_comb begin
    wvalid_s = (level_q != {LW{1'b0}});
    xfer_s   = wvalid_s & bus.word_ready;
    pop_s    = xfer_s & (idx_q == 2'd3);
    cap_s    = bus.AES_data_out_valid & ~prev_v_q;
    full_s   = (level_q == LW'(DEPTH));
    // A final-word pop frees the head slot, so a full FIFO can still accept.
    accept_s = cap_s & (~full_s | pop_s);
    drop_s   = cap_s & full_s & ~pop_s;
  end

  // Next-state for edge detect, word index, pointers, level and overflow.
  always_comb begin
    prev_v_d = bus.AES_data_out_valid;
    idx_d    = idx_q;
    head_d   = head_q;
    tail_d   = tail_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    if (xfer_s) begin
      idx_d = idx_q + 2'd1;
    end else begin
      idx_d = idx_q;
    end
    if (pop_s) begin
      head_d = head_q + AW'(1'b1);
    end else begin
      head_d = head_q;
    end
    if (accept_s) begin
      tail_d = tail_q + AW'(1'b1);
    end else begin
      tail_d = tail_q;
    end
    if (drop_s) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_q;
    end
    case ({accept_s, pop_s})
      2'b10:   level_d = level_q + LW'(1'b1);
      2'b01:   level_d = level_q - LW'(1'b1);
      default: level_d = level_q;
    endcase
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge AES_clk) begin
    if (!AES_rst_n) begin
      prev_v_q <= 1'b0;
      idx_q    <= 2'd0;
      head_q   <= {AW{1'b0}};
      tail_q   <= {AW{1'b0}};
      level_q  <= {LW{1'b0}};
      ovf_q    <= 1'b0;
    end else begin
      prev_v_q <= prev_v_d;
      idx_q    <= idx_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

  // Block storage; contents survive reset, only the pointers are cleared.
  always_ff @(posedge AES_clk) begin
    if (AES_rst_n && accept_s) begin
      mem_q[tail_q] <= bus.AES_data_out;
    end
  end

  // Word selection from the head block; forced to zero while idle.
  always_comb begin
    head_blk_s = mem_q[head_q];
    sel_s      = MSW_FIRST ? (2'd3 - idx_q) : idx_q;
    case (sel_s)
      2'd0:    word_s = head_blk_s[31:0];
      2'd1:    word_s = head_blk_s[63:32];
      2'd2:    word_s = head_blk_s[95:64];
      2'd3:    word_s = head_blk_s[127:96];
      default: word_s = 32'd0;
    endcase
    if (!wvalid_s) begin
      word_s = 32'd0;
    end else begin
      word_s = word_s;
    end
  end

  assign bus.word_valid = wvalid_s;
  assign bus.word_data  = word_s;
  assign bus.word_last  = wvalid_s & (idx_q == 2'd3);
  assign bus.buf_level  = level_q;
  assign bus.overflow   = ovf_q;
`ifdef AES_OUT_PARITY_EN
  assign bus.word_parity = even_parity(word_s);
`endif
endmodule

// File: doc/aes_out_serializer.md
# aes_out_serializer

- Downstream capture stage for `AES_top`.
- Latches each 128-bit result presented on `AES_data_out` when `AES_data_out_valid` rises, and holds it in a small FIFO of whole blocks.
- Emits each block as four 32-bit words over a valid/ready handshake, so narrow consumers (bus bridge, UART/SPI framer, checker) can drain ciphertext at their own rate without stalling the core.

## Interface

Parameters:
- `DEPTH`, default 2: number of 128-bit entries; power of two, ≥2.
- `MSW_FIRST`, default 1: 1 sends bits [127:96] first; 0 sends bits [31:0] first.

Ports:
- `AES_clk` input 1: single clock; all state updates on its rising edge.
- `AES_rst_n` input 1: reset, synchronous and active-low.
- `AES_data_out_valid` input 1: result-valid from `AES_top`.
- `AES_data_out` input 128: result block from `AES_top`.
- `word_ready` input 1: consumer accepts `word_data` this cycle.
- `word_valid` output 1: `word_data` is valid.
- `word_data` output 32: current word of the head block.
- `word_last` output 1: current word is the 4th word of its block.
- `buf_level` output $clog2(DEPTH)+1: number of blocks held, including a partially sent one.
- `overflow` output 1: sticky flag; set when a block was dropped.
- `word_parity` output 1: present only with `AES_OUT_PARITY_EN`.

## Operation

**Capture**
- Register `prev_v` holds the previous cycle's `AES_data_out_valid`.
- A capture event is `AES_data_out_valid & ~prev_v`. A result held high for several cycles is captured exactly once.
- On a capture event with `buf_level < DEPTH`, `AES_data_out` is written at the tail pointer.
- On a capture event with `buf_level == DEPTH` and no pop in the same cycle, the block is dropped and `overflow` is set. `overflow` stays 1 until reset.
- When a capture event and the final-word pop of the head block fall in the same cycle while full, the write is accepted. The pop frees the slot first, and `buf_level` stays at DEPTH.

**Serialize**
- `word_valid = (buf_level != 0)`.
- Word index counter `idx` (2 bits) selects the word:
  - `MSW_FIRST=1`: `idx`=0..3 maps to bits [127:96], [95:64], [63:32], [31:0].
  - `MSW_FIRST=0`: the reverse order.
- A transfer occurs when `word_valid & word_ready`.
- On a transfer with `idx<3`, `idx` increments.
- On a transfer with `idx==3`, `idx` wraps to 0, the head pointer advances and `buf_level` decrements (unless a simultaneous capture is accepted).
- `word_last = word_valid & (idx==3)`.
- While `word_valid & ~word_ready`, `word_data`, `word_last` and `word_parity` hold stable.
- Head and tail pointers wrap modulo DEPTH.
- `buf_level` updates:
  - +1 on an accepted capture with no pop.
  - −1 on a pop with no accepted capture.
  - Unchanged when both or neither occur.

**Reset**
- Reset is sampled only at an `AES_clk` edge with `AES_rst_n`=0.
- It clears `prev_v`, `idx`, both pointers, `buf_level` and `overflow`.
- Reset outputs: `word_valid`=0, `word_last`=0, `buf_level`=0, `overflow`=0, `word_parity`=0, `word_data`=0. `word_data` is forced to 0 whenever `word_valid`=0.
- FIFO storage is not cleared.
- Reset mid-block discards every stored and partially sent block. No word is emitted after the reset edge.
- If `AES_data_out_valid` is already high when reset releases, it is captured on the first edge after release, because `prev_v`=0.

## Timing

- Capture edge N, FIFO previously empty: `word_valid`=1 and the first word is on `word_data` in cycle N+1.
- With `word_ready` held high, the four words occupy cycles N+1..N+4, and `word_valid` falls in N+5 unless another block is queued.
- Back-to-back queued blocks stream with no idle cycle between the last word of one and the first word of the next.
- Sustained throughput is one word per cycle, one block per 4 cycles. Blocks arriving faster than that fill the FIFO.
- No combinational path from `AES_data_out_valid` or `AES_data_out` to any output.
- `word_last` and `word_parity` are combinational from registered state.
- `word_ready` affects only next-state logic.

## Configuration

- Macro `AES_OUT_PARITY_EN`.
- Defined: port `word_parity` exists and equals the even parity (`^word_data`) of the current word. It is 0 when `word_valid`=0.
- Undefined: the port and its logic are absent. All other behaviour is identical.

## Test plan

- **Single block, no backpressure:** reset, then one valid pulse with `AES_data_out`=128'h00112233_44556677_8899aabb_ccddeeff and `word_ready`=1 → `word_data` = 00112233, 44556677, 8899aabb, ccddeeff on four consecutive cycles starting one cycle after capture; `word_last`=1 only on ccddeeff; `buf_level` returns to 0.
- **Held valid:** `AES_data_out_valid` held high 5 cycles → exactly one block emitted; `buf_level` peaks at 1.
- **Backpressure:** `word_ready` dropped for 3 cycles while 44556677 is presented → 44556677 stays on `word_data` with `word_valid`=1 for all 3 cycles; the sequence then resumes with no loss or duplication.
- **Overflow:** DEPTH=2, `word_ready`=0, three separate valid pulses → `buf_level`=2, `overflow`=1, and only the first two blocks drain once ready rises.
- **Reset mid-block:** reset asserted after 2 words are transferred → next cycle `word_valid`=0, `buf_level`=0, `overflow`=0.
- **Parity (macro defined):** block 128'h00000007_00000003_00000000_ffffffff → `word_parity` = 1, 0, 0, 0 across the four words.
